// File: rtl/vga_digit_renderer.sv
// Text-pixel stage: maps pixel coordinates onto six 8x8 digit glyphs and emits a 2-tick pipelined RGB stream.
// Optional feature macro: VGA_DIGIT_BLINK_EN (adds blink_sel and a frame counter for digit blinking).
module vga_digit_renderer #(
   parameter int unsigned X0         = 256,
   parameter int unsigned Y0         = 224,
   parameter int unsigned SCALE_LOG2 = 2,
   parameter int unsigned V_ACTIVE   = 480,
   parameter logic [7:0]  FG_COLOR   = 8'hFF,
   parameter logic [7:0]  BG_COLOR   = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_tick,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic [23:0] digits_in,
   input  logic        upd_req,
`ifdef VGA_DIGIT_BLINK_EN
   input  logic [2:0]  blink_sel,
`endif
   output logic        upd_ack,
   output logic        busy,
   output logic [2:0]  direccion,
   output logic [3:0]  rom,
   input  logic [7:0]  rom_data,
   output logic [7:0]  rgb,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam int unsigned CW      = 10;
   localparam logic [CW-1:0] X0_V  = CW'(X0);
   localparam logic [CW-1:0] Y0_V  = CW'(Y0);
   localparam logic [CW-1:0] VA_V  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] FLD_W = CW'(48 << SCALE_LOG2);
   localparam logic [CW-1:0] FLD_H = CW'(8 << SCALE_LOG2);

   logic [CW-1:0] w_dx, w_dy;
   logic          w_in_field, w_frame, w_blank, w_bit;
   logic [2:0]    w_idx, w_col, w_row;
   logic [3:0]    w_digit;

   logic [23:0]   r_shadow, r_display;
   logic          r_busy, r_ack;
   logic [2:0]    r_dir, r_col;
   logic [3:0]    r_rom;
   logic          r_show, r_video, r_hs, r_vs;
   logic [7:0]    r_rgb;
   logic          r_hs_out, r_vs_out;

   // Wrapped negative offsets become large unsigned values and fall outside the field.
   assign w_dx       = pixel_x - X0_V;
   assign w_dy       = pixel_y - Y0_V;
   assign w_in_field = (w_dx < FLD_W) && (w_dy < FLD_H);
   assign w_idx      = 3'(w_dx >> (3 + SCALE_LOG2));
   assign w_col      = 3'(w_dx >> SCALE_LOG2);
   assign w_row      = 3'(w_dy >> SCALE_LOG2);
   assign w_frame    = pix_tick && (pixel_x == '0) && (pixel_y == VA_V);
   assign w_bit      = rom_data[3'd7 - r_col];

   always_comb begin
      w_digit = 4'h0;
      case (w_idx)
         3'd0:    w_digit = r_display[23:20];
         3'd1:    w_digit = r_display[19:16];
         3'd2:    w_digit = r_display[15:12];
         3'd3:    w_digit = r_display[11:8];
         3'd4:    w_digit = r_display[7:4];
         3'd5:    w_digit = r_display[3:0];
         default: w_digit = 4'h0;
      endcase
   end

`ifdef VGA_DIGIT_BLINK_EN
   logic [5:0] r_frame_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         r_frame_cnt <= '0;
      else if (w_frame) r_frame_cnt <= r_frame_cnt + 6'd1;
   end

   // blink_sel >= 6 never matches an in-field index, so blinking is off.
   assign w_blank = (w_idx == blink_sel) && r_frame_cnt[5];
`else
   assign w_blank = 1'b0;
`endif

   // Shadow/display double buffer; a request on the frame point queues behind the transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shadow  <= '0;
         r_display <= '0;
         r_busy    <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         if (w_frame && r_busy) begin
            r_display <= r_shadow;
            r_ack     <= 1'b1;
            r_busy    <= 1'b0;
         end
         if (upd_req) begin
            r_shadow <= digits_in;
            r_busy   <= 1'b1;
         end
      end
   end

   // Stage 1: ROM address and pixel attributes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dir   <= '0;
         r_rom   <= '0;
         r_col   <= '0;
         r_show  <= 1'b0;
         r_video <= 1'b0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
      end else if (pix_tick) begin
         r_col   <= w_col;
         r_show  <= w_in_field && !w_blank;
         r_video <= video_on;
         r_hs    <= hsync_in;
         r_vs    <= vsync_in;
         if (w_in_field) begin
            r_dir <= w_row;
            r_rom <= w_digit;
         end
      end
   end

   // Stage 2: glyph bit to colour, syncs delayed alongside.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rgb    <= '0;
         r_hs_out <= 1'b1;
         r_vs_out <= 1'b1;
      end else if (pix_tick) begin
         r_rgb    <= !r_video ? 8'h00 : ((r_show && w_bit) ? FG_COLOR : BG_COLOR);
         r_hs_out <= r_hs;
         r_vs_out <= r_vs;
      end
   end

   assign upd_ack   = r_ack;
   assign busy      = r_busy;
   assign direccion = r_dir;
   assign rom       = r_rom;
   assign rgb       = r_rgb;
   assign hsync_out = r_hs_out;
   assign vsync_out = r_vs_out;

endmodule

// File: tb/tb_vga_digit_renderer.sv
// Bench for vga_digit_renderer: directed steps plus random pixels against an arithmetic pixel model.
module tb_vga_digit_renderer;

   typedef struct packed {
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_tick, video_on, hsync_in, vsync_in, upd_req;
   logic [9:0]  pixel_x, pixel_y;
   logic [23:0] digits_in;
   logic        upd_ack, busy, hsync_out, vsync_out;
   logic [2:0]  direccion;
   logic [3:0]  rom;
   logic [7:0]  rom_data, rgb;
`ifdef VGA_DIGIT_BLINK_EN
   logic [2:0]  blink_sel = 3'd2;
`endif

   logic [7:0]  glyph [16][8];
   int          total = 0;
   int          bad   = 0;

   logic [23:0] m_disp, m_shadow;
   logic        m_busy;
   logic [3:0]  m_rom;
   logic [2:0]  m_dir;
   int          m_frames;
   exp_t        q[$];

   vga_digit_renderer dut (
      .clk       (clk),
      .rst       (rst),
      .pix_tick  (pix_tick),
      .video_on  (video_on),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .digits_in (digits_in),
      .upd_req   (upd_req),
`ifdef VGA_DIGIT_BLINK_EN
      .blink_sel (blink_sel),
`endif
      .upd_ack   (upd_ack),
      .busy      (busy),
      .direccion (direccion),
      .rom       (rom),
      .rom_data  (rom_data),
      .rgb       (rgb),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out)
   );

   always #5 clk = ~clk;

   assign rom_data = glyph[rom][direccion];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected colour of one screen pixel with the current model display contents.
   function automatic logic [7:0] pix_model(input int x, input int y, input logic v);
      int dx, dy, c, col, row;
      logic [3:0] dg;
      dx = x - 256;
      dy = y - 224;
      if (!v) return 8'h00;
      if (dx < 0 || dx >= 192 || dy < 0 || dy >= 32) return 8'h00;
      c   = dx / 32;
      col = (dx / 4) % 8;
      row = dy / 4;
      dg  = 4'(m_disp >> (4 * (5 - c)));
`ifdef VGA_DIGIT_BLINK_EN
      if (c == int'(blink_sel) && ((m_frames / 32) % 2) == 1) return 8'h00;
`endif
      return glyph[dg][row][7-col] ? 8'hFF : 8'h00;
   endfunction

   task automatic model_reset();
      m_disp   = '0;
      m_shadow = '0;
      m_busy   = 1'b0;
      m_rom    = '0;
      m_dir    = '0;
      m_frames = 0;
      q.delete();
      q.push_back('{rgb: 8'h00, hs: 1'b1, vs: 1'b1});
   endtask

   // One pix_tick with optional update request, then 'gap' idle clocks.
   task automatic do_tick(input int x, input int y, input logic v, input int gap,
                          input logic req, input logic [23:0] d);
      exp_t e;
      logic h, s, ack_exp, fp;
      int   dx, dy;
      h = 1'($urandom);
      s = 1'($urandom);
      pixel_x = 10'(x); pixel_y = 10'(y); video_on = v;
      hsync_in = h; vsync_in = s; pix_tick = 1'b1;
      upd_req = req; digits_in = d;
      e.rgb = pix_model(x, y, v); e.hs = h; e.vs = s;
      q.push_back(e);
      dx = x - 256;
      dy = y - 224;
      if (dx >= 0 && dx < 192 && dy >= 0 && dy < 32) begin
         m_dir = 3'(dy / 4);
         m_rom = 4'(m_disp >> (4 * (5 - dx / 32)));
      end
      fp      = (x == 0) && (y == 480);
      ack_exp = fp && m_busy;
      if (fp) begin
         if (m_busy) begin
            m_disp = m_shadow;
            m_busy = 1'b0;
         end
         m_frames++;
      end
      if (req) begin
         m_shadow = d;
         m_busy   = 1'b1;
      end
      @(posedge clk); #1;
      pix_tick = 1'b0;
      upd_req  = 1'b0;
      e = q.pop_front();
      chk("rgb", 32'(rgb), 32'(e.rgb));
      chk("hsync_out", 32'(hsync_out), 32'(e.hs));
      chk("vsync_out", 32'(vsync_out), 32'(e.vs));
      chk("rom", 32'(rom), 32'(m_rom));
      chk("direccion", 32'(direccion), 32'(m_dir));
      chk("upd_ack", 32'(upd_ack), 32'(ack_exp));
      chk("busy", 32'(busy), 32'(m_busy));
      repeat (gap) begin
         @(posedge clk); #1;
         chk("hold_rgb", 32'(rgb), 32'(e.rgb));
         chk("hold_rom", 32'(rom), 32'(m_rom));
         chk("ack_low", 32'(upd_ack), 32'd0);
      end
   endtask

   initial begin
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 8; r++)
            glyph[c][r] = 8'($urandom);
      rst = 1'b0; pix_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      pixel_x = '0; pixel_y = '0; digits_in = '0; upd_req = 1'b0;
      model_reset();

      // Reset held with ticks running
      repeat (4) begin
         pixel_x = 10'(256 + $urandom_range(0, 191)); pixel_y = 10'd230;
         video_on = 1'b1; hsync_in = 1'($urandom); vsync_in = 1'($urandom);
         pix_tick = 1'b1;
         @(posedge clk); #1;
         pix_tick = 1'b0;
         chk("rst_rgb", 32'(rgb), 32'd0);
         chk("rst_hs", 32'(hsync_out), 32'd1);
         chk("rst_vs", 32'(vsync_out), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_ack", 32'(upd_ack), 32'd0);
         chk("rst_rom", 32'(rom), 32'd0);
         chk("rst_dir", 32'(direccion), 32'd0);
      end
      #2 rst = 1'b1;

      // Latency scan across the left edge with display 0
      for (int x = 255; x <= 300; x++) do_tick(x, 224, 1'b1, 0, 1'b0, 24'h0);

      // Mapping check with 123456
      do_tick(100, 100, 1'b1, 1, 1'b1, 24'h123456);
      do_tick(0, 480, 1'b0, 1, 1'b0, 24'h0);
      do_tick(256 + 32*3 + 5, 224 + 9, 1'b1, 0, 1'b0, 24'h0);
      chk("map_rom", 32'(rom), 32'd4);
      chk("map_dir", 32'(direccion), 32'd2);
      do_tick(300, 300, 1'b1, 0, 1'b0, 24'h0);

      // Handshake: pending update does not disturb the displayed digits
      do_tick(300, 230, 1'b1, 0, 1'b1, 24'h235959);
      for (int x = 256; x < 448; x += 8) do_tick(x, 228, 1'b1, 0, 1'b0, 24'h0);
      do_tick(0, 480, 1'b0, 2, 1'b0, 24'h0);
      for (int x = 256; x < 448; x += 4) do_tick(x, 224 + 4 * ((x / 4) % 8), 1'b1, 0, 1'b0, 24'h0);

      // Collision of a new request with the frame point
      do_tick(50, 50, 1'b1, 0, 1'b1, 24'h111111);
      do_tick(0, 480, 1'b0, 1, 1'b1, 24'h000001);
      for (int x = 256; x < 448; x += 16) do_tick(x, 236, 1'b1, 0, 1'b0, 24'h0);
      do_tick(0, 480, 1'b0, 1, 1'b0, 24'h0);
      for (int x = 256; x < 448; x += 16) do_tick(x, 244, 1'b1, 0, 1'b0, 24'h0);

      // Random pixels, gaps, repeated requests and frame points
      for (int i = 0; i < 400; i++) begin
         int x, y, sel;
         sel = int'($urandom_range(0, 19));
         if (sel == 0) begin
            x = 0; y = 480;
         end else if (sel < 4) begin
            x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
         end else begin
            x = int'($urandom_range(240, 460)); y = int'($urandom_range(215, 265));
         end
         do_tick(x, y, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 15) == 0), 24'($urandom));
      end

      // Frame sequence crossing 64 frames, sampling every digit column
      do_tick(10, 10, 1'b1, 0, 1'b1, 24'h987654);
      for (int f = 0; f < 70; f++) begin
         do_tick(0, 480, 1'b0, 0, 1'b0, 24'h0);
         do_tick(256 + 32 * (f % 6) + 4 * (f % 8), 224 + 4 * (f % 8), 1'b1, 0, 1'b0, 24'h0);
      end

      // Asynchronous reset in mid-frame
      do_tick(256 + 40, 230, 1'b1, 0, 1'b1, 24'h445566);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("arst_rgb", 32'(rgb), 32'd0);
      chk("arst_hs", 32'(hsync_out), 32'd1);
      chk("arst_vs", 32'(vsync_out), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rom", 32'(rom), 32'd0);
      chk("arst_dir", 32'(direccion), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int x = 300; x < 340; x += 4) do_tick(x, 226, 1'b1, 0, 1'b0, 24'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
